// File: rtl/vis_readback_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vis_readback_pkg                                           |
// | Description : Shared configuration for the visibility read-out engine:   |
// |               accumulator width, sweep geometry and FSM state encoding.  |
// | Ports       : none (package)                                             |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
package vis_readback_pkg;

   localparam int DEF_ACCUM_BITS = 24;   // Re/Im accumulator width
   localparam int DEF_BLOCKS     = 24;   // correlator blocks per sweep
   localparam int DEF_BBITS      = 5;    // block-index width
   localparam int DEF_TRATE      = 12;   // words per block (time slots)
   localparam int DEF_TBITS      = 4;    // tick-index width

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/vis_readback_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vis_readback_if                                            |
// | Description : Bundles the accumulator-SRAM read port and the outgoing    |
// |               valid/ready visibility stream of the read-out engine.      |
// | Ports       : master = engine side  (drives rd_*, s_valid/s_data/s_last) |
// |               slave  = SRAM/FIFO side (drives rd_data, s_ready)          |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
interface vis_readback_if
   import vis_readback_pkg::*;
#(
   parameter int WIDTH = 2*DEF_ACCUM_BITS,
   parameter int BBITS = DEF_BBITS,
   parameter int TBITS = DEF_TBITS
);
   logic             rd_en;
   logic [BBITS-1:0] rd_blk;
   logic [TBITS-1:0] rd_tick;
   logic [WIDTH-1:0] rd_data;
   logic             s_valid;
   logic             s_ready;
   logic [WIDTH-1:0] s_data;
   logic             s_last;

   modport master (
      output rd_en, rd_blk, rd_tick, s_valid, s_data, s_last,
      input  rd_data, s_ready
   );

   modport slave (
      input  rd_en, rd_blk, rd_tick, s_valid, s_data, s_last,
      output rd_data, s_ready
   );
endinterface
`default_nettype wire

// File: rtl/vis_readback_skid2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vis_readback_skid2                                         |
// | Description : 2-entry valid/ready skid buffer. The head word is held     |
// |               stable until it is accepted; outputs read 0 when empty.    |
// | Ports       : clk_x, rst (async, active high)                            |
// |               in_valid/in_data   : write side (no back-pressure; caller  |
// |                                    must respect count)                   |
// |               out_valid/out_ready/out_data : stream side                 |
// |               count              : words currently buffered (0..2)       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module vis_readback_skid2 #(
   parameter int DW = 49
) (
   input  wire           clk_x,
   input  wire           rst,
   input  wire           in_valid,
   input  wire  [DW-1:0] in_data,
   output logic          out_valid,
   input  wire           out_ready,
   output logic [DW-1:0] out_data,
   output logic [1:0]    count
);
   logic [DW-1:0] r_mem [2];
   logic          r_wr_ptr;
   logic          r_rd_ptr;
   logic [1:0]    r_count;
   logic          w_push;
   logic          w_pop;

   assign w_pop  = (r_count != 2'd0) && out_ready;
   // A full buffer can still take a word in the cycle its head leaves.
   assign w_push = in_valid && ((r_count != 2'd2) || w_pop);

   always_ff @(posedge clk_x or posedge rst) begin
      if (rst) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wr_ptr <= 1'b0;
         r_rd_ptr <= 1'b0;
         r_count  <= 2'd0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop)
            r_rd_ptr <= ~r_rd_ptr;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign out_valid = (r_count != 2'd0);
   // Stale entries are masked so an empty buffer never shows a leftover last flag.
   assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
   assign count     = r_count;

endmodule
`default_nettype wire

// File: rtl/vis_readback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : vis_readback                                               |
// | Description : After each bank switch, sweeps every (block, tick) address |
// |               of the inactive accumulator bank, reads the {sin,cos}      |
// |               words (1-cycle SRAM latency) and streams them out in       |
// |               address order through a 2-entry skid buffer.               |
// | Ports       : clk_x, rst (async, active high)                            |
// |               start : bank-switch strobe    clr  : clear overrun flag    |
// |               bus   : SRAM read port + output stream (master modport)    |
// |               busy  : sweep in progress     done : end-of-sweep pulse    |
// |               overrun : sticky, start seen while busy                    |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module vis_readback
   import vis_readback_pkg::*;
#(
   parameter int ACCUM  = DEF_ACCUM_BITS,
   parameter int WIDTH  = 2*ACCUM,
   parameter int BLOCKS = DEF_BLOCKS,
   parameter int BBITS  = DEF_BBITS,
   parameter int TRATE  = DEF_TRATE,
   parameter int TBITS  = DEF_TBITS
) (
   input  wire            clk_x,
   input  wire            rst,
   input  wire            start,
   input  wire            clr,
   vis_readback_if.master bus,
   output logic           busy,
   output logic           done,
   output logic           overrun
);
   localparam logic [BBITS-1:0] c_blk_last  = BBITS'(BLOCKS-1);
   localparam logic [TBITS-1:0] c_tick_last = TBITS'(TRATE-1);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [BBITS-1:0] r_blk;
   logic [TBITS-1:0] r_tick;
   logic             r_inflight;       // read issued last cycle, data on rd_data now
   logic             r_inflight_last;  // that read was the final address
   logic             r_done;
   logic             r_overrun;
   logic             w_rd_en;
   logic             w_done_nxt;
   logic             w_addr_last;
   logic             w_pop;
   logic             w_s_valid;
   logic             w_s_last;
   logic [WIDTH-1:0] w_s_data;
   logic [1:0]       w_count;
   logic [2:0]       w_used;

   assign w_addr_last = (r_blk == c_blk_last) && (r_tick == c_tick_last);
   assign w_pop       = w_s_valid & bus.s_ready;
   // Slots committed at the end of this cycle: buffered + in flight, minus the
   // word leaving now. Discounting the pop keeps 1 word/cycle with s_ready high.
   assign w_used      = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};

   always_comb begin
      w_state_nxt = r_state;
      w_rd_en     = 1'b0;
      w_done_nxt  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // First read goes out in the start cycle so the first word is
            // presented two cycles after start.
            if (start && !rst) begin
               w_rd_en     = 1'b1;
               w_state_nxt = w_addr_last ? ST_DRAIN : ST_READ;
            end
         end
         ST_READ: begin
            if (w_used < 3'd2) begin
               w_rd_en = 1'b1;
               if (w_addr_last)
                  w_state_nxt = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (!r_inflight && (w_used == 3'd0)) begin
               w_state_nxt = ST_IDLE;
               w_done_nxt  = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_x or posedge rst) begin
      if (rst) begin
         r_state         <= ST_IDLE;
         r_blk           <= '0;
         r_tick          <= '0;
         r_inflight      <= 1'b0;
         r_inflight_last <= 1'b0;
         r_done          <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         r_state         <= w_state_nxt;
         r_inflight      <= w_rd_en;
         r_inflight_last <= w_rd_en & w_addr_last;
         r_done          <= w_done_nxt;
         if (w_rd_en) begin
            if (r_tick == c_tick_last) begin
               r_tick <= '0;
               r_blk  <= w_addr_last ? '0 : r_blk + 1'b1;
            end else begin
               r_tick <= r_tick + 1'b1;
            end
         end
         // Set has priority over clear.
         if (start && (r_state != ST_IDLE))
            r_overrun <= 1'b1;
         else if (clr)
            r_overrun <= 1'b0;
      end
   end

   vis_readback_skid2 #(
      .DW (WIDTH+1)
   ) u_skid (
      .clk_x     (clk_x),
      .rst       (rst),
      .in_valid  (r_inflight),
      .in_data   ({r_inflight_last, bus.rd_data}),
      .out_valid (w_s_valid),
      .out_ready (bus.s_ready),
      .out_data  ({w_s_last, w_s_data}),
      .count     (w_count)
   );

   assign bus.rd_en   = w_rd_en;
   assign bus.rd_blk  = r_blk;
   assign bus.rd_tick = r_tick;
   assign bus.s_valid = w_s_valid;
   assign bus.s_data  = w_s_data;
   assign bus.s_last  = w_s_last;
   assign busy        = (r_state != ST_IDLE);
   assign done        = r_done;
   assign overrun     = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_vis_readback.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_vis_readback                                            |
// | Description : Self-checking bench for vis_readback. Each sweep fills a   |
// |               random bank image and queues its 288 words in address      |
// |               order; a monitor pops and compares every handshake.        |
// | Ports       : none                                                       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_vis_readback;
   import vis_readback_pkg::*;

   localparam int WIDTH  = 2*DEF_ACCUM_BITS;
   localparam int NWORDS = DEF_BLOCKS*DEF_TRATE;

   logic clk_x = 1'b0;
   logic rst   = 1'b1;
   logic start = 1'b0;
   logic clr   = 1'b0;
   logic busy;
   logic done;
   logic overrun;

   vis_readback_if bus ();

   vis_readback dut (
      .clk_x   (clk_x),
      .rst     (rst),
      .start   (start),
      .clr     (clr),
      .bus     (bus),
      .busy    (busy),
      .done    (done),
      .overrun (overrun)
   );

   always #5 clk_x = ~clk_x;

   int             n_checks = 0;
   int             n_errors = 0;
   logic [WIDTH:0] exp_q [$];
   logic [WIDTH-1:0] mem [NWORDS];
   int             exp_rd_idx = 0;
   int             issued = 0;
   int             accepted = 0;
   int             hs_count = 0;
   bit             done_due = 1'b0;
   bit             prev_stall = 1'b0;
   logic [WIDTH:0] prev_word;
   logic [WIDTH:0] exp_word;
   int             ready_mode = 1;   // 0 low, 1 high, 2 toggle, 3 random

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // Accumulator SRAM: one-cycle read latency.
   always @(posedge clk_x)
      if (bus.rd_en)
         bus.rd_data <= mem[int'(bus.rd_blk)*DEF_TRATE + int'(bus.rd_tick)];

   initial begin
      bus.s_ready = 1'b0;
      forever begin
         @(posedge clk_x);
         #1;
         case (ready_mode)
            0:       bus.s_ready = 1'b0;
            1:       bus.s_ready = 1'b1;
            2:       bus.s_ready = ~bus.s_ready;
            default: bus.s_ready = 1'($urandom_range(0, 1));
         endcase
      end
   end

   // Monitor / scoreboard
   always @(negedge clk_x) begin
      if (rst) begin
         exp_q.delete();
         exp_rd_idx = 0;
         issued     = 0;
         accepted   = 0;
         prev_stall = 1'b0;
         done_due   = 1'b0;
      end else begin
         if (done || done_due)
            check("done_pulse", 64'(done), 64'(done_due));
         if (done)
            check("busy_on_done", 64'(busy), 64'd0);
         done_due = 1'b0;
         if (prev_stall) begin
            check("hold_valid", 64'(bus.s_valid), 64'd1);
            check("hold_word", 64'({bus.s_last, bus.s_data}), 64'(prev_word));
         end
         if (bus.rd_en) begin
            check("rd_addr", 64'({bus.rd_blk, bus.rd_tick}),
                  64'({DEF_BBITS'(exp_rd_idx / DEF_TRATE), DEF_TBITS'(exp_rd_idx % DEF_TRATE)}));
            exp_rd_idx = (exp_rd_idx + 1) % NWORDS;
            issued++;
         end
         if (bus.s_valid && bus.s_ready) begin
            accepted++;
            hs_count++;
            if (exp_q.size() == 0) begin
               n_checks++;
               n_errors++;
               $display("FAIL unexpected_word: actual %0h required none", {bus.s_last, bus.s_data});
            end else begin
               exp_word = exp_q.pop_front();
               check("word", 64'({bus.s_last, bus.s_data}), 64'(exp_word));
            end
            if (bus.s_last)
               done_due = 1'b1;
         end
         if (bus.rd_en)
            check("credits", 64'((issued - accepted) <= 2), 64'd1);
         prev_stall = bus.s_valid && !bus.s_ready;
         prev_word  = {bus.s_last, bus.s_data};
      end
   end

   // Fresh bank image, queue its words in sweep order, raise start.
   task automatic sweep_begin();
      for (int i = 0; i < NWORDS; i++) begin
         mem[i] = WIDTH'({$urandom(), $urandom()});
         exp_q.push_back({(i == NWORDS-1), mem[i]});
      end
      start = 1'b1;
   endtask

   task automatic start_end();
      @(posedge clk_x);
      #1 start = 1'b0;
   endtask

   task automatic wait_hs(input int n);
      int base;
      base = hs_count;
      for (int k = 0; k < 4000 && (hs_count - base) < n; k++)
         @(negedge clk_x);
   endtask

   task automatic wait_done(input string name, input int bound);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < bound && !seen; k++) begin
         @(negedge clk_x);
         if (done) seen = 1'b1;
      end
      check(name, 64'(seen), 64'd1);
   endtask

   initial begin
      int n;
      // Reset state
      repeat (3) @(posedge clk_x);
      @(negedge clk_x);
      check("rst_rd_en", 64'(bus.rd_en), 64'd0);
      check("rst_s_valid", 64'(bus.s_valid), 64'd0);
      check("rst_s_data", 64'(bus.s_data), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_overrun", 64'(overrun), 64'd0);
      check("rst_addr", 64'({bus.rd_blk, bus.rd_tick}), 64'd0);
      @(posedge clk_x);
      #1 rst = 1'b0;

      // Full-rate sweep: latency, throughput, done timing
      ready_mode = 1;
      @(posedge clk_x);
      #1 sweep_begin();
      @(negedge clk_x);
      check("t1_rd_en_start", 64'(bus.rd_en), 64'd1);
      check("t1_valid_c0", 64'(bus.s_valid), 64'd0);
      start_end();
      @(negedge clk_x);
      check("t1_valid_c1", 64'(bus.s_valid), 64'd0);
      @(negedge clk_x);
      check("t1_valid_c2", 64'(bus.s_valid), 64'd1);
      n = 0;
      while (!done && n < 600) begin
         @(negedge clk_x);
         n++;
      end
      check("t1_done_cycle", 64'(n), 64'd288);
      check("t1_busy_low", 64'(busy), 64'd0);
      check("t1_queue_empty", 64'(exp_q.size()), 64'd0);

      // Toggling ready
      ready_mode = 2;
      @(posedge clk_x);
      #1 sweep_begin();
      start_end();
      wait_done("t2_done", 3000);
      check("t2_queue_empty", 64'(exp_q.size()), 64'd0);

      // Overrun and clr behaviour
      ready_mode = 1;
      @(posedge clk_x);
      #1 sweep_begin();
      start_end();
      wait_hs(100);
      @(posedge clk_x);
      #1 start = 1'b1;
      start_end();
      @(negedge clk_x);
      check("t3_overrun_set", 64'(overrun), 64'd1);
      wait_hs(50);
      @(posedge clk_x);
      #1 clr = 1'b1;
      @(posedge clk_x);
      #1 clr = 1'b0;
      @(negedge clk_x);
      check("t3_overrun_clr", 64'(overrun), 64'd0);
      wait_hs(30);
      @(posedge clk_x);
      #1 begin start = 1'b1; clr = 1'b1; end
      @(posedge clk_x);
      #1 begin start = 1'b0; clr = 1'b0; end
      @(negedge clk_x);
      check("t3_set_wins", 64'(overrun), 64'd1);
      wait_done("t3_done", 1000);
      check("t3_queue_empty", 64'(exp_q.size()), 64'd0);
      @(posedge clk_x);
      #1 clr = 1'b1;
      @(posedge clk_x);
      #1 clr = 1'b0;
      @(negedge clk_x);
      check("t3_overrun_clr2", 64'(overrun), 64'd0);

      // Reset mid-sweep
      ready_mode = 3;
      @(posedge clk_x);
      #1 sweep_begin();
      start_end();
      wait_hs(50);
      @(posedge clk_x);
      #1 rst = 1'b1;
      #1;
      check("t4_rd_en", 64'(bus.rd_en), 64'd0);
      check("t4_s_valid", 64'(bus.s_valid), 64'd0);
      check("t4_s_data", 64'({bus.s_last, bus.s_data}), 64'd0);
      check("t4_busy", 64'(busy), 64'd0);
      check("t4_addr", 64'({bus.rd_blk, bus.rd_tick}), 64'd0);
      repeat (2) @(posedge clk_x);
      #1 rst = 1'b0;
      ready_mode = 1;
      @(posedge clk_x);
      #1 sweep_begin();
      @(negedge clk_x);
      check("t4_restart_addr", 64'({bus.rd_en, bus.rd_blk, bus.rd_tick}),
            64'({1'b1, DEF_BBITS'(0), DEF_TBITS'(0)}));
      start_end();

      // Start on the done cycle
      n = 0;
      while (!(bus.s_valid && bus.s_ready && bus.s_last) && n < 1000) begin
         @(negedge clk_x);
         n++;
      end
      check("t5_last_seen", 64'(n < 1000), 64'd1);
      @(posedge clk_x);
      #1 sweep_begin();
      @(negedge clk_x);
      check("t5_done_now", 64'(done), 64'd1);
      check("t5_accepted", 64'(bus.rd_en), 64'd1);
      start_end();
      @(negedge clk_x);
      check("t5_busy", 64'(busy), 64'd1);
      wait_done("t5_done", 1000);
      check("t5_no_overrun", 64'(overrun), 64'd0);
      check("t5_queue_empty", 64'(exp_q.size()), 64'd0);

      // Downstream stalled for 20 cycles
      ready_mode = 0;
      @(posedge clk_x);
      #1 sweep_begin();
      @(negedge clk_x);
      n = int'(bus.rd_en);
      start_end();
      repeat (19) begin
         @(negedge clk_x);
         n += int'(bus.rd_en);
      end
      check("t6_reads_stalled", 64'(n), 64'd2);
      check("t6_valid_held", 64'(bus.s_valid), 64'd1);
      ready_mode = 3;
      wait_done("t6_done", 3000);
      check("t6_queue_empty", 64'(exp_q.size()), 64'd0);

      repeat (3) @(negedge clk_x);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
